mem_writeback: RTL and testbench
================================

MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  EX/MEM op present.
REQ-005 in_ready  output  1  unit can accept an op; combinational, 1 iff state==IDLE.
REQ-006 alu_result  input  32  ALU result or effective address.
REQ-007 store_data  input  32  rs2 value for stores.
REQ-008 rd_in  input  5  destination register.
REQ-009 reg_write_in  input  1  op writes rd.
REQ-010 mem_read / mem_write  input  1 each  load / store op.
REQ-011 funct3  input  3  access size/sign.
REQ-012 mem_req  output  1  data-memory request, registered.
REQ-013 mem_we  output  1  1=store.
REQ-014 mem_addr  output  32  word address, {alu_result[31:2],2'b00}.
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_wstrb  output  4  byte enables.
REQ-017 mem_ack  input  1  memory done; mem_rdata valid same cycle.
REQ-018 mem_rdata  input  32  load word.
REQ-019 write_reg  output  1  register-file write pulse, registered.
REQ-020 rd  output  5  write destination.
REQ-021 write_back_data  output  32  value written to rd.
REQ-022 err  output  1  one-cycle pulse: misaligned, illegal funct3, read+write both set, or timeout.

Function
REQ-023 SHALL implement FSM states IDLE and MEM; op accepted when in_valid && in_ready.
REQ-024 Non-memory op accepted in cycle N: write_reg=reg_write_in&&(rd_in!=0), rd, write_back_data=alu_result in cycle N+1 for exactly one cycle; state stays IDLE.
REQ-025 Legal memory op accepted in cycle N: state->MEM, mem_req=1 from cycle N+1; mem_addr/mem_we/mem_wdata/mem_wstrb held stable until and including the ack cycle.
REQ-026 In MEM, cycle with mem_ack=1: mem_req=0 and state=IDLE from next cycle; in_ready high next cycle.
REQ-027 Load ack in cycle M: write_reg pulse in cycle M+1 (suppressed if rd_in==0 or reg_write_in==0) with extended data; a new op may be accepted in cycle M+1.
REQ-028 Store: no write_reg pulse.
REQ-029 Load extend, lane=addr[1:0]: lb 000 sign-extend rdata[8*lane+:8]; lbu 100 zero-extend; lh 001 sign-extend rdata[16*addr[1]+:16]; lhu 101 zero-extend; lw 010 full word.
REQ-030 Store: sb 000 wdata={4{data[7:0]}}, wstrb=0001<<lane; sh 001 wdata={2{data[15:0]}}, wstrb=addr[1]?1100:0011; sw 010 wdata=data, wstrb=1111.
REQ-031 Misaligned (half with addr[0]=1; word with addr[1:0]!=0), illegal funct3, or mem_read&&mem_write: err pulse in cycle N+1, no mem_req, no write_reg, stay IDLE.
REQ-032 8-bit wait counter cleared on entry to MEM, increments each MEM cycle without ack; at count 255 without ack: drop mem_req, err pulse next cycle, no write_reg, return IDLE.
REQ-033 mem_ack while IDLE SHALL be ignored.
REQ-034 Outputs write_reg, err SHALL be zero in every cycle not specified above.

Reset
REQ-035 On rst: state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, write_reg=0, err=0, rd=0, write_back_data=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-036 Reset during MEM abandons the access: mem_req low next cycle, no write_reg, a subsequent ack is ignored.

Verification
REQ-037 ALU op alu_result=0x1234_5678, rd_in=5, reg_write_in=1 -> next cycle write_reg=1, rd=5, data=0x1234_5678, one cycle only.
REQ-038 lb addr=0x103, ack after 3 cycles with rdata=0x80xx_xxxx -> mem_req held 3 cycles, mem_addr=0x100, then write_back_data=0xFFFF_FF80.
REQ-039 sh addr=0x202, store_data=0x0000_BEEF -> mem_we=1, wdata=0xBEEF_BEEF, wstrb=1100, no write_reg after ack.
REQ-040 lw addr=0x101 -> err pulse next cycle, mem_req never asserted, in_ready stays 1.
REQ-041 Load with no ack for 255 MEM cycles -> mem_req drops, err pulse, late ack ignored.
REQ-042 rst asserted mid-MEM, ack the following cycle -> no write_reg, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_writeback.sv
// Memory/writeback stage: ALU ops retire next cycle; loads/stores hold a registered request until mem_ack or a 256-cycle timeout.
// Latency: ALU 1 cycle, memory op 1 cycle after ack; in_ready is low for the whole MEM phase, so the op source stalls.
module mem_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        write_reg,
    output logic [4:0]  rd,
    output logic [31:0] write_back_data,
    output logic        err
);
    typedef enum logic {IDLE, MEM} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  op_f3;
    logic [1:0]  op_lane;
    logic        op_load;
    logic        op_wr;
    logic [4:0]  op_rd;

    logic        is_mem;
    logic        f3_ok;
    logic        misaligned;
    logic        bad;
    logic [1:0]  lane;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] rsh;
    logic [15:0] half_v;
    logic [31:0] ld_data;

    assign in_ready = (state == IDLE);
    assign lane     = alu_result[1:0];

    always_comb begin
        is_mem = mem_read | mem_write;
        f3_ok  = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~mem_write;  // unsigned sizes exist only for loads
            default:                f3_ok = 1'b0;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                     ((funct3[1:0] == 2'b10) & (lane != 2'b00));
        bad = (mem_read & mem_write) | ~f3_ok | misaligned;

        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << lane;
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = store_data;
                st_wstrb = 4'b1111;
            end
        endcase

        rsh    = mem_rdata >> {op_lane, 3'b000};
        half_v = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_f3)
            3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
            3'b100:  ld_data = {24'd0, rsh[7:0]};
            3'b001:  ld_data = {{16{half_v[15]}}, half_v};
            3'b101:  ld_data = {16'd0, half_v};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= 8'd0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'd0;
            mem_wdata       <= 32'd0;
            mem_wstrb       <= 4'd0;
            write_reg       <= 1'b0;
            rd              <= 5'd0;
            write_back_data <= 32'd0;
            err             <= 1'b0;
            op_f3           <= 3'd0;
            op_lane         <= 2'd0;
            op_load         <= 1'b0;
            op_wr           <= 1'b0;
            op_rd           <= 5'd0;
        end else begin
            write_reg <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            write_reg       <= reg_write_in && (rd_in != 5'd0);
                            rd              <= rd_in;
                            write_back_data <= alu_result;
                        end else if (bad) begin
                            err <= 1'b1;
                        end else begin
                            state     <= MEM;
                            wait_cnt  <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_addr  <= {alu_result[31:2], 2'b00};
                            mem_wdata <= mem_write ? st_wdata : 32'd0;
                            mem_wstrb <= mem_write ? st_wstrb : 4'd0;
                            op_f3     <= funct3;
                            op_lane   <= lane;
                            op_load   <= mem_read;
                            op_wr     <= reg_write_in && (rd_in != 5'd0);
                            op_rd     <= rd_in;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (op_load) begin
                            write_reg       <= op_wr;
                            rd              <= op_rd;
                            write_back_data <= ld_data;
                        end
                    end else if (wait_cnt == 8'hFF) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed vector table, hand sequences for timing corners, randomized ops against a transaction model.
module tb_mem_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        write_reg;
    logic [4:0]  rd;
    logic [31:0] write_back_data;
    logic        err;

    mem_writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .write_reg(write_reg), .rd(rd),
        .write_back_data(write_back_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rdi;
        logic        rw;
        logic [31:0] rdata;
        int          dly;      // cycles with mem_req high, ack on the last one
        logic        e_err;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_wr;
        logic [31:0] e_data;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic mr, input logic mw, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] rdi, input logic rw,
                                 input logic [31:0] rdata, input int dly,
                                 input logic e_err, input logic e_req,
                                 input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                 input logic [3:0] e_wstrb, input logic e_wr,
                                 input logic [31:0] e_data);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.sdata = sdata;
        v.rdi = rdi; v.rw = rw; v.rdata = rdata; v.dly = dly;
        v.e_err = e_err; v.e_req = e_req; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_wstrb = e_wstrb; v.e_wr = e_wr; v.e_data = e_data;
        return v;
    endfunction

    // Transaction-level reference: access size in bytes, alignment by modulo, extension by arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int sz;
        int off;
        bit uns;
        logic [31:0] val;
        r = v;
        r.e_err = 0; r.e_req = 0; r.e_addr = 0; r.e_wdata = 0; r.e_wstrb = 0;
        r.e_wr = 0; r.e_data = 0;
        if (!v.mr && !v.mw) begin
            r.e_wr = v.rw && (v.rdi != 0);
            r.e_data = v.addr;
            return r;
        end
        uns = 0;
        case (v.f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: begin sz = 1; uns = 1; end
            3'd5: begin sz = 2; uns = 1; end
            default: sz = 0;
        endcase
        if (sz == 0 || (v.mr && v.mw) || (v.mw && uns) || (v.addr % sz != 0)) begin
            r.e_err = 1;
            return r;
        end
        off = int'(v.addr % 4);
        r.e_req = 1;
        r.e_addr = v.addr - (v.addr % 4);
        if (v.mw) begin
            r.e_wstrb = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++)
                r.e_wdata[8*i +: 8] = 8'(v.sdata >> (8 * (i % sz)));
        end else begin
            val = v.rdata >> (8 * off);
            if (sz < 4) begin
                val = val & 32'((1 << (8 * sz)) - 1);
                if (!uns && val >= 32'(1 << (8 * sz - 1)))
                    val = val - 32'(1 << (8 * sz));
            end
            r.e_wr = v.rw && (v.rdi != 0);
            r.e_data = val;
        end
        return r;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        in_valid = 1; mem_read = v.mr; mem_write = v.mw; funct3 = v.f3;
        alu_result = v.addr; store_data = v.sdata; rd_in = v.rdi; reg_write_in = v.rw;
        @(negedge clk);
        chk({tag, " in_ready_at_issue"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        if (v.e_req) begin
            for (int c = 1; c <= v.dly; c++) begin
                mem_ack = (c == v.dly);
                mem_rdata = (c == v.dly) ? v.rdata : $urandom;
                @(negedge clk);
                chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, " mem_addr"}, mem_addr, v.e_addr);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(v.mw));
                if (v.mw) begin
                    chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
                    chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.e_wstrb));
                end
                chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
                chk({tag, " write_reg_busy"}, 32'(write_reg), 32'd0);
                chk({tag, " err_busy"}, 32'(err), 32'd0);
                @(posedge clk); #1;
                mem_ack = 0;
                mem_rdata = $urandom;
            end
        end
        @(negedge clk);
        chk({tag, " write_reg"}, 32'(write_reg), 32'(v.e_wr));
        if (v.e_wr) begin
            chk({tag, " rd"}, 32'(rd), 32'(v.rdi));
            chk({tag, " wb_data"}, write_back_data, v.e_data);
        end
        chk({tag, " err"}, 32'(err), 32'(v.e_err));
        chk({tag, " mem_req_after"}, 32'(mem_req), 32'd0);
        chk({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " write_reg_pulse_end"}, 32'(write_reg), 32'd0);
        chk({tag, " err_pulse_end"}, 32'(err), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " write_reg"}, 32'(write_reg), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " rd"}, 32'(rd), 32'd0);
        chk({tag, " wb_data"}, write_back_data, 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   n;
        bit   done;

        rst = 1; in_valid = 0; alu_result = 0; store_data = 0; rd_in = 0;
        reg_write_in = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 0;

        // ack while idle must not produce anything
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 0;
        @(negedge clk);
        chk("idle_ack write_reg", 32'(write_reg), 32'd0);
        chk("idle_ack err", 32'(err), 32'd0);
        chk("idle_ack mem_req", 32'(mem_req), 32'd0);
        chk("idle_ack in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        //           mr mw f3    addr          sdata         rd  rw rdata         dly err req e_addr        e_wdata       strb     wr e_data
        tbl.push_back(mkv(0, 0, 3'd0, 32'h1234_5678, 32'h0,        5'd5, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'h0,    1, 32'h1234_5678));
        tbl.push_back(mkv(0, 0, 3'd0, 32'h0000_00AA, 32'h0,        5'd0, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd0, 32'h0000_0103, 32'h0,        5'd7, 1, 32'h8012_3456, 3, 0, 1, 32'h0000_0100, 32'h0,        4'h0,    1, 32'hFFFF_FF80));
        tbl.push_back(mkv(0, 1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 5'd9, 1, 32'h0,        2, 0, 1, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd2, 32'h0000_0101, 32'h0,        5'd3, 1, 32'h0,        0, 1, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd4, 32'h0000_0101, 32'h0,        5'd4, 1, 32'h0000_9A00, 1, 0, 1, 32'h0000_0100, 32'h0,        4'h0,    1, 32'h0000_009A));
        tbl.push_back(mkv(1, 0, 3'd1, 32'h0000_0102, 32'h0,        5'd6, 1, 32'h8001_0000, 2, 0, 1, 32'h0000_0100, 32'h0,        4'h0,    1, 32'hFFFF_8001));
        tbl.push_back(mkv(1, 0, 3'd5, 32'h0000_0102, 32'h0,        5'd6, 1, 32'h8001_0000, 1, 0, 1, 32'h0000_0100, 32'h0,        4'h0,    1, 32'h0000_8001));
        tbl.push_back(mkv(1, 0, 3'd2, 32'h0000_000C, 32'h0,        5'd31, 1, 32'hDEAD_BEEF, 1, 0, 1, 32'h0000_000C, 32'h0,       4'h0,    1, 32'hDEAD_BEEF));
        tbl.push_back(mkv(0, 1, 3'd0, 32'h0000_0013, 32'h1234_56AB, 5'd2, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 32'hABAB_ABAB, 4'b1000, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D, 5'd2, 1, 32'h0,        4, 0, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd1, 32'h0000_0201, 32'h0,        5'd8, 1, 32'h0,        0, 1, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0));
        tbl.push_back(mkv(1, 1, 3'd2, 32'h0000_0040, 32'h0,        5'd8, 1, 32'h0,        0, 1, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd3, 32'h0000_0040, 32'h0,        5'd8, 1, 32'h0,        0, 1, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0));
        tbl.push_back(mkv(0, 1, 3'd4, 32'h0000_0040, 32'h0,        5'd8, 1, 32'h0,        0, 1, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd2, 32'h0000_0044, 32'h0,        5'd8, 0, 32'h5555_AAAA, 2, 0, 1, 32'h0000_0044, 32'h0,       4'h0,    0, 32'h0));
        tbl.push_back(mkv(1, 0, 3'd0, 32'h0000_0045, 32'h0,        5'd0, 1, 32'h0000_FF00, 1, 0, 1, 32'h0000_0044, 32'h0,       4'h0,    0, 32'h0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // load acked in M, new ALU op accepted in M+1
        in_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; alu_result = 32'h10;
        rd_in = 5'd3; reg_write_in = 1;
        @(posedge clk); #1;
        in_valid = 0; mem_ack = 1; mem_rdata = 32'h1122_3344;
        @(posedge clk); #1;
        mem_ack = 0;
        in_valid = 1; mem_read = 0; alu_result = 32'h55; rd_in = 5'd4;
        @(negedge clk);
        chk("b2b in_ready_M1", 32'(in_ready), 32'd1);
        chk("b2b load write_reg", 32'(write_reg), 32'd1);
        chk("b2b load rd", 32'(rd), 32'd3);
        chk("b2b load data", write_back_data, 32'h1122_3344);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("b2b alu write_reg", 32'(write_reg), 32'd1);
        chk("b2b alu rd", 32'(rd), 32'd4);
        chk("b2b alu data", write_back_data, 32'h55);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b write_reg_end", 32'(write_reg), 32'd0);
        @(posedge clk); #1;

        // timeout: no ack, request lasts while the wait counter runs 0..255
        in_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; alu_result = 32'h80;
        rd_in = 5'd9; reg_write_in = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                if (err || write_reg) begin
                    chk("timeout early pulse", 32'({err, write_reg}), 32'd0);
                end
            end else begin
                done = 1;
                chk("timeout err", 32'(err), 32'd1);
                chk("timeout write_reg", 32'(write_reg), 32'd0);
                chk("timeout in_ready", 32'(in_ready), 32'd1);
            end
            @(posedge clk); #1;
        end
        chk("timeout ended", 32'(done), 32'd1);
        chk("timeout req_cycles", 32'(n), 32'd256);
        mem_ack = 1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mem_ack = 0;
        @(negedge clk);
        chk("late_ack write_reg", 32'(write_reg), 32'd0);
        chk("late_ack err", 32'(err), 32'd0);
        chk("late_ack mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;

        // reset during MEM, ack right after
        in_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd0; alu_result = 32'h103;
        rd_in = 5'd12; reg_write_in = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("rst_mid mem_req_before", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; mem_ack = 1; mem_rdata = 32'h8000_0000;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        mem_ack = 0;
        @(negedge clk);
        chk("rst_mid post_ack write_reg", 32'(write_reg), 32'd0);
        chk("rst_mid post_ack mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid post_ack in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // randomized ops against the model
        for (int i = 0; i < 200; i++) begin
            int k;
            k = $urandom_range(0, 9);
            v.mr = (k >= 3 && k <= 5) || k == 9;
            v.mw = (k >= 6);
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.sdata = $urandom;
            v.rdi = 5'($urandom_range(0, 31));
            v.rw = 1'($urandom_range(0, 1));
            v.rdata = $urandom;
            v.dly = $urandom_range(1, 5);
            v = model(v);
            run_vec(v, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
